// File: rtl/inv_rounds.sv
// inv_rounds: one AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns) sequenced by a small FSM over a single 128-bit working state.
// Optional build macro INV_ROUND_DWELL_EN: every transform stage occupies
// STAGE_DWELL cycles and its transform is applied on the last of them.
module inv_rounds #(
    parameter int STAGE_DWELL = 6
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         start,
    input  logic [3:0]   rc,
    input  logic [127:0] data,
    input  logic [127:0] keyin,
    output logic [127:0] rndout,
    output logic         done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {S_IDLE, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] st;
    logic [127:0] key_q;
    logic [3:0]   rc_q;
    logic         stage_last;
    logic         capture;
    logic         reject;

    if (STAGE_DWELL < 1 || STAGE_DWELL > 255) begin : g_bad_dwell
        $error("STAGE_DWELL must lie in 1..255");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as y^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] sq;
        logic [7:0] r;
        y  = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        sq = y;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Byte k of the state sits at [127-8k -: 8]; k = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef INV_ROUND_DWELL_EN
    localparam logic [7:0] DWELL_LAST = 8'(STAGE_DWELL - 1);
    logic [7:0] dwell_cnt;

    assign stage_last = (dwell_cnt == DWELL_LAST);

    // Dwell counter: counts cycles within a transform stage, clears on stage exit.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            dwell_cnt <= 8'd0;
        else if ((state == S_ISR || state == S_ISB || state == S_ARK || state == S_IMC) && !stage_last)
            dwell_cnt <= dwell_cnt + 8'd1;
        else
            dwell_cnt <= 8'd0;
    end
`else
    assign stage_last = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; rc=10 skips straight to the key addition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && rc <= 4'd10) state_nxt = (rc == 4'd10) ? S_ARK : S_ISR;
            S_ISR:  if (stage_last) state_nxt = S_ISB;
            S_ISB:  if (stage_last) state_nxt = S_ARK;
            S_ARK:  if (stage_last) state_nxt = (rc_q >= 4'd1 && rc_q <= 4'd9) ? S_IMC : S_DONE;
            S_IMC:  if (stage_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/decode logic: busy, accepted start, rejected start.
    always_comb begin
        busy    = (state != S_IDLE);
        capture = (state == S_IDLE) && start && (rc <= 4'd10);
        reject  = (state == S_IDLE) && start && (rc > 4'd10);
    end

    // Round key and variant are latched at capture so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (capture) begin
            key_q <= keyin;
            rc_q  <= rc;
        end
    end

    // Working state, result register and the done/err pulses.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            st     <= '0;
            rndout <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            case (state)
                S_IDLE: if (capture)    st <= data;
                S_ISR:  if (stage_last) st <= inv_shift_rows(st);
                S_ISB:  if (stage_last) st <= inv_sub_bytes(st);
                S_ARK:  if (stage_last) st <= st ^ key_q;
                S_IMC:  if (stage_last) st <= inv_mix_columns(st);
                S_DONE: begin
                    rndout <= st;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_rounds.sv
// Testbench for inv_rounds: scoreboard of expected results and done times,
// filled by the stimulus process and drained by a monitor on every done pulse.
module tb_inv_rounds;

    localparam int DW = 6;
`ifdef INV_ROUND_DWELL_EN
    localparam int DWELL = DW;
`else
    localparam int DWELL = 1;
`endif

    logic         clk;
    logic         rst_;
    logic         start;
    logic [3:0]   rc;
    logic [127:0] data;
    logic [127:0] keyin;
    logic [127:0] rndout;
    logic         done;
    logic         busy;
    logic         err;

    typedef struct {
        logic [127:0] val;
        int           t;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [127:0] last_out = '0;
    logic [7:0]   inv_sb [256];

    inv_rounds #(.STAGE_DWELL(DW)) dut (
        .clk(clk), .rst_(rst_), .start(start), .rc(rc), .data(data),
        .keyin(keyin), .rndout(rndout), .done(done), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // GF(2^8) multiply, shift-and-add over the multiplier bits.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res, aa, bb;
        res = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) res = res ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    // Reference inverse round on a 4x4 row/column byte matrix.
    function automatic logic [127:0] ref_round(input int r, input logic [127:0] d, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) s[i][c] = d[127-8*(4*c+i) -: 8];
        if (r != 10) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) t[i][(c+i)%4] = s[i][c];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) s[i][c] = inv_sb[t[i][c]];
        end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) s[i][c] = s[i][c] ^ k[127-8*(4*c+i) -: 8];
        if (r >= 1 && r <= 9) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) a[i] = s[i][c];
                for (int i = 0; i < 4; i++)
                    s[i][c] = gmul(8'h0e, a[i]) ^ gmul(8'h0b, a[(i+1)%4]) ^
                              gmul(8'h0d, a[(i+2)%4]) ^ gmul(8'h09, a[(i+3)%4]);
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) o[127-8*(4*c+i) -: 8] = s[i][c];
        return o;
    endfunction

    function automatic int latency(input int r);
        int stages;
        if (r == 10) stages = 1;
        else if (r == 0) stages = 3;
        else stages = 4;
        return 1 + stages * DWELL;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every done pulse retires the oldest expectation.
    always @(negedge clk) begin
        if (rst_) begin
            if (done || err) chk("done_err_exclusive", {127'd0, done && err}, 128'd0);
            if (err) chk("err_while_busy", {127'd0, busy}, 128'd0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rndout", rndout, e.val);
                    chk("done_cycle", 128'(cyc), 128'(e.t));
                    last_out = e.val;
                end
            end else begin
                chk("rndout_hold", rndout, last_out);
            end
        end
    end

    // Wait (at negedges) until idle, pestering the DUT with random inputs meanwhile.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            start = 1'($urandom_range(0, 1));
            rc    = 4'($urandom);
            data  = rnd128();
            keyin = rnd128();
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 128'd1, 128'd0);
    endtask

    task automatic issue(input logic [3:0] r, input logic [127:0] d, input logic [127:0] k,
                         input bit use_kat, input logic [127:0] kat);
        exp_t e;
        wait_idle();
        start = 1'b1; rc = r; data = d; keyin = k;
        if (r <= 4'd10) begin
            e.val = use_kat ? kat : ref_round(int'(r), d, k);
            e.t   = cyc + 1 + latency(int'(r));
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; rc = 4'($urandom); data = rnd128(); keyin = rnd128();
        if (r <= 4'd10) begin
            chk("busy_after_start", {127'd0, busy}, 128'd1);
        end else begin
            chk("err_pulse", {127'd0, err}, 128'd1);
            chk("busy_on_reject", {127'd0, busy}, 128'd0);
            @(negedge clk);
            chk("err_one_cycle", {127'd0, err}, 128'd0);
        end
    endtask

    initial begin
        rst_ = 1'b0; start = 1'b0; rc = 4'd0; data = '0; keyin = '0;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av, inv, sv;
            av  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
            sv = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_sb[sv] = av;
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_err", {127'd0, err}, 128'd0);
        chk("reset_rndout", rndout, 128'd0);
        rst_ = 1'b1;
        @(negedge clk);

        issue(4'd10, 128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              1'b1, 128'he9317db5cb322c723d2e895faf090794);
        issue(4'd1, 128'h49db873b453953897f02d2f177de961a, 128'ha0fafe1788542cb123a339392a6c7605,
              1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        issue(4'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              1'b1, 128'h3243f6a8885a308d313198a2e0370734);
        issue(4'd12, rnd128(), rnd128(), 1'b0, '0);

        for (int i = 0; i < 40; i++)
            issue(4'($urandom_range(0, 15)), rnd128(), rnd128(), 1'b0, '0);

        // Reset in the middle of an rc=1 round.
        issue(4'd1, rnd128(), rnd128(), 1'b0, '0);
        @(negedge clk);
        #2 rst_ = 1'b0;
        q.delete();
        last_out = '0;
        #1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_rndout", rndout, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        issue(4'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              1'b1, 128'h3243f6a8885a308d313198a2e0370734);

        wait_idle();
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_rounds.md
INV_ROUNDS -- requirements
Module: inv_rounds

Interface
REQ-001 Parameter: STAGE_DWELL, default 6, cycles each transform stage occupies when INV_ROUND_DWELL_EN is defined (legal 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one inverse round; sampled only in IDLE.
REQ-005 rc  input  4  round-key index (0..10) selecting the round variant.
REQ-006 data  input  128  round input state, byte 0 at [127:120].
REQ-007 keyin  input  128  round key for index rc, from the external key schedule.
REQ-008 rndout  output  128  registered round result.
REQ-009 done  output  1  one-cycle pulse; rndout valid.
REQ-010 busy  output  1  high whenever FSM not in IDLE.
REQ-011 err  output  1  one-cycle pulse on rejected start.

Function
REQ-012 FSM states SHALL be IDLE, ISR, ISB, ARK, IMC, DONE; one 128-bit working register st.
REQ-013 IDLE, start=1, rc<=10: st<=data, key register<=keyin, rc register<=rc; next ISR if rc<=9, else ARK.
REQ-014 IDLE, start=1, rc in 11..15: no capture, err=1 next cycle, remain IDLE.
REQ-015 ISR: st<=InvShiftRows(st) -> ISB; ISB: st<=InvSubBytes(st) -> ARK.
REQ-016 ARK: st<=st^key; next IMC if captured rc in 1..9, else DONE.
REQ-017 IMC: st<=InvMixColumns(st) over GF(2^8), poly 0x11B -> DONE.
REQ-018 DONE: rndout<=st, done=1 for exactly one cycle, -> IDLE.
REQ-019 Variants: rc=10 whitening only (ARK); rc=1..9 ISR,ISB,ARK,IMC; rc=0 ISR,ISB,ARK.
REQ-020 Latency (dwell off), start-sampling edge to done high: rc=10 2 cycles, rc=1..9 5 cycles, rc=0 4 cycles.
REQ-021 start while busy SHALL be ignored; data/keyin/rc changes after capture SHALL not affect the result.
REQ-022 rndout SHALL hold its value from DONE until the next DONE; busy low in IDLE only.
REQ-023 start may be asserted in the cycle after done (back-to-back rounds, no bubble beyond IDLE).
REQ-024 err and done SHALL never assert in the same cycle.

Reset
REQ-025 rst_ low SHALL immediately force IDLE, rndout=0, st=0, done=0, busy=0, err=0, any dwell counter=0.
REQ-026 Reset mid-round SHALL abort with no done pulse; first start after rst_ release is processed normally.

Configuration
REQ-027 Macro INV_ROUND_DWELL_EN defined: each of ISR, ISB, ARK, IMC holds STAGE_DWELL cycles via an 8-bit dwell counter, transform applied on the final dwell cycle; latency = 1 + stages*STAGE_DWELL.
REQ-028 Macro undefined: no dwell counter, one cycle per stage, latencies per REQ-020.

Verification
REQ-029 rc=10, data=3925841d02dc09fbdc118597196a0b32, keyin=d014f9a8c9ee2589e13f0cc8b6630ca6 -> rndout=e9317db5cb322c723d2e895faf090794, done 2 cycles after start.
REQ-030 rc=1, data=49db873b453953897f02d2f177de961a, keyin=a0fafe1788542cb123a339392a6c7605 -> rndout=d4bf5d30e0b452aeb84111f11e2798e5, done after 5 cycles.
REQ-031 rc=0, data=d4bf5d30e0b452aeb84111f11e2798e5, keyin=2b7e151628aed2a6abf7158809cf4f3c -> rndout=3243f6a8885a308d313198a2e0370734, done after 4 cycles.
REQ-032 rc=12 with start -> err pulse one cycle, busy stays 0, rndout unchanged; second start during busy -> ignored, single done.
REQ-033 rst_ low 2 cycles after an rc=1 start -> busy=0, rndout=0 at once, no done; subsequent rc=0 vector completes correctly.
REQ-034 INV_ROUND_DWELL_EN, STAGE_DWELL=6, REQ-030 vector -> same rndout, done 25 cycles after start.
